// File: rtl/repairclk_pkg.sv
// rtl/repairclk_pkg.sv - shared encodings and window helper for the REPAIRCLK pattern detector
package repairclk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DETECT = 2'd1,
    ST_DONE   = 2'd2,
    ST_HOLD   = 2'd3
  } det_state_e;

  typedef enum logic {
    LANE_HUNT  = 1'b0,
    LANE_CHECK = 1'b1
  } lane_state_e;

  // Bit positions of each clock-track lane in the result vector.
  localparam int RCKP      = 0;
  localparam int RCKN      = 1;
  localparam int RTRK      = 2;
  localparam int NUM_LANES = 3;

  // Detection window: every iteration the partner sends, plus slack for
  // pipeline skew between the partner's enable and our own.
  function automatic int unsigned calc_window(input int unsigned iter_total,
                                              input int unsigned pulse_ui,
                                              input int unsigned low_ui,
                                              input int unsigned margin);
    return iter_total * (pulse_ui + low_ui) + margin;
  endfunction

endpackage

// File: rtl/repairclk_lane_detector.sv
// rtl/repairclk_lane_detector.sv - per-lane clock repair pattern checker with sticky pass flag
module repairclk_lane_detector
  import repairclk_pkg::*;
#(
  parameter int unsigned PULSE_UI      = 16,
  parameter int unsigned LOW_UI        = 8,
  parameter int unsigned DETECT_THRESH = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic clear_i,
  input  logic bit_i,
  output logic pass_next_o
);

  localparam int unsigned ITER_UI = PULSE_UI + LOW_UI;
  localparam int unsigned POS_W   = (ITER_UI > 1) ? $clog2(ITER_UI) : 1;
  localparam int unsigned CNT_W   = $clog2(DETECT_THRESH + 1);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(ITER_UI - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DETECT_THRESH);

  lane_state_e      state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] consec_q, consec_d;
  logic             pass_q, pass_d;
  logic             prev_q;
  logic             expected;

  // Next-state logic: clear beats everything, inactive lanes park in HUNT.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    consec_d = consec_q;
    pass_d   = pass_q;
    expected = 1'b0;

    if (clear_i) begin
      state_d  = LANE_HUNT;
      pos_d    = '0;
      consec_d = '0;
      pass_d   = 1'b0;
    end else if (!active_i) begin
      state_d  = LANE_HUNT;
      pos_d    = '0;
      consec_d = '0;
    end else begin
      case (state_q)
        LANE_HUNT: begin
          // A rising edge marks UI 0 of an iteration; the next UI is position 1.
          if (bit_i && !prev_q) begin
            state_d = LANE_CHECK;
            pos_d   = POS_W'(1);
          end
        end
        LANE_CHECK: begin
          expected = (32'(pos_q) < PULSE_UI) ? ~pos_q[0] : 1'b0;
          if (bit_i != expected) begin
            consec_d = '0;
            // An unexpected rising edge may itself be the start of a fresh burst.
            if (bit_i && !prev_q) begin
              pos_d = POS_W'(1);
            end else begin
              state_d = LANE_HUNT;
              pos_d   = '0;
            end
          end else if (pos_q == POS_LAST) begin
            pos_d = '0;
            if (consec_q != CNT_MAX) begin
              consec_d = consec_q + 1'b1;
            end
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
        default: state_d = LANE_HUNT;
      endcase

      if (consec_d == CNT_MAX) begin
        pass_d = 1'b1;
      end
    end
  end

  // State registers; previous UI is tracked every cycle so edge detection
  // is valid on the very first cycle of a window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= LANE_HUNT;
      pos_q    <= '0;
      consec_q <= '0;
      pass_q   <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      consec_q <= consec_d;
      pass_q   <= pass_d;
      prev_q   <= bit_i;
    end
  end

  // Next-cycle pass flag lets the top capture an iteration that completes
  // in the same cycle the window closes.
  assign pass_next_o = pass_d;

endmodule

// File: rtl/repairclk_pattern_detector.sv
// rtl/repairclk_pattern_detector.sv - receive-side REPAIRCLK pattern detector (window FSM and result)
module repairclk_pattern_detector
  import repairclk_pkg::*;
#(
  parameter int unsigned PULSE_UI      = 16,
  parameter int unsigned LOW_UI        = 8,
  parameter int unsigned ITER_TOTAL    = 128,
  parameter int unsigned DETECT_THRESH = 16,
  parameter int unsigned WINDOW_MARGIN = 16
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       i_detect_en,
  input  logic       i_clear_clk_detection,
  input  logic       i_rckp,
  input  logic       i_rckn,
  input  logic       i_rtrk,
  output logic [2:0] o_clock_track_result_logged,
  output logic       o_clk_track_done,
  output logic       o_busy
);

  localparam int unsigned WINDOW = calc_window(ITER_TOTAL, PULSE_UI, LOW_UI, WINDOW_MARGIN);
  localparam int unsigned WIN_W  = $clog2(WINDOW);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  det_state_e             state_q, state_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [2:0]             result_q, result_d;
  logic                   lane_clear;
  logic                   lane_active;
  logic [NUM_LANES-1:0]   lane_bits;
  logic [NUM_LANES-1:0]   lane_pass_next;

  assign lane_bits[RCKP] = i_rckp;
  assign lane_bits[RCKN] = i_rckn;
  assign lane_bits[RTRK] = i_rtrk;
  assign lane_active     = (state_q == ST_DETECT);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    repairclk_lane_detector #(
      .PULSE_UI      (PULSE_UI),
      .LOW_UI        (LOW_UI),
      .DETECT_THRESH (DETECT_THRESH)
    ) u_lane (
      .clk_i       (CLK),
      .rst_i       (rst),
      .active_i    (lane_active),
      .clear_i     (lane_clear),
      .bit_i       (lane_bits[g]),
      .pass_next_o (lane_pass_next[g])
    );
  end

  // Window FSM next state; the clear pulse overrides every transition.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    result_d   = result_q;
    lane_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_detect_en) begin
          state_d    = ST_DETECT;
          win_d      = '0;
          result_d   = '0;
          lane_clear = 1'b1;
        end
      end
      ST_DETECT: begin
        if (win_q == WIN_LAST || !i_detect_en) begin
          // Result is captured on the way into DONE so it is valid with the strobe.
          state_d  = ST_DONE;
          result_d = lane_pass_next;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Enable must drop before another window can start.
        if (!i_detect_en) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_clear_clk_detection) begin
      state_d    = ST_IDLE;
      win_d      = '0;
      result_d   = '0;
      lane_clear = 1'b1;
    end
  end

  // FSM, window counter and logged result registers.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      result_q <= result_d;
    end
  end

  assign o_clock_track_result_logged = result_q;
  assign o_clk_track_done            = (state_q == ST_DONE) && !i_clear_clk_detection;
  assign o_busy                      = (state_q == ST_DETECT);

endmodule

// File: doc/repairclk_pattern_detector.md
Name: repairclk_pattern_detector

Overview:
- Receive-side counterpart of the MBINIT REPAIRCLK transmit pattern enable: checks the clock repair pattern arriving on RCKP, RCKN and RTRK.
- Produces the 3-bit clock-track result consumed by the REPAIRCLK partner logic as the comparator result, plus a completion strobe.
- Sits in LTSM/MBINIT, after the lane samplers. Input is one UI per lane per CLK cycle.

Parameters:
- PULSE_UI, 16: UIs of toggling (1,0,1,0,...) per iteration, starting with 1; must be even.
- LOW_UI, 8: UIs held low after the pulse burst in each iteration.
- ITER_TOTAL, 128: iterations sent by the partner transmitter.
- DETECT_THRESH, 16: consecutive error-free iterations needed for a lane to pass.
- WINDOW_MARGIN, 16: extra cycles added to the detection window.

Ports:
- CLK  in  1  block clock.
- rst  in  1  reset; synchronous, active-high.
- i_detect_en  in  1  level; detection window runs while high.
- i_clear_clk_detection  in  1  pulse; clears logged result and aborts detection.
- i_rckp  in  1  sampled RCKP UI.
- i_rckn  in  1  sampled RCKN UI.
- i_rtrk  in  1  sampled RTRK UI.
- o_clock_track_result_logged  out  3  bit0 = RCKP pass, bit1 = RCKN pass, bit2 = RTRK pass.
- o_clk_track_done  out  1  one-cycle strobe; result valid in the same cycle.
- o_busy  out  1  high in DETECT.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, lane detectors in HUNT, all counters 0.
- Window length: W = ITER_TOTAL*(PULSE_UI+LOW_UI) + WINDOW_MARGIN. This is 3088 with default parameters.
- FSM states:
  - IDLE: if i_detect_en=1, go to DETECT, clear pass flags and window counter, set lane detectors to HUNT. Logged result is kept until the next DETECT entry.
  - DETECT: o_busy=1; window counter increments every cycle. Go to DONE when the counter reaches W-1, or when i_detect_en=0 (early end).
  - DONE (single cycle): latch the pass flags into o_clock_track_result_logged; o_clk_track_done=1. Go to HOLD.
  - HOLD: wait for i_detect_en=0, then go to IDLE. Detection cannot retrigger until i_detect_en falls.
- i_clear_clk_detection has priority over every state and over simultaneous entry into DETECT:
  - next state IDLE; result and pass flags set to 0; no done strobe.
  - If i_detect_en is still high after a clear, the next cycle re-enters DETECT.
- Lane detector, one per lane, identical. It is active only in DETECT and held in HUNT otherwise.
  - HUNT: the previous UI is tracked. A 0->1 transition starts an iteration: position = 1, go to CHECK.
  - CHECK: expected bit for position p is (p < PULSE_UI) ? ~p[0] : 0.
    - Mismatch: consec = 0. If the mismatched bit is 1 and the previous bit was 0, restart the iteration at position 1 and stay in CHECK; otherwise go to HUNT.
    - Position PULSE_UI+LOW_UI-1 matched: iteration complete. consec is incremented and saturates at DETECT_THRESH; position wraps to 0.
  - Pass flag: set when consec reaches DETECT_THRESH; sticky until the next DETECT entry or clear.
  - Counter widths: consec uses clog2(DETECT_THRESH+1) bits; position uses clog2(PULSE_UI+LOW_UI) bits; window counter uses clog2(W) bits.
- Boundary cases:
  - An iteration still in progress when the window ends does not count.
  - If the final increment and the window end land in the same cycle, the increment counts: DONE samples the updated flags.
  - Stuck-at-0 or stuck-at-1 lanes never pass.
  - Reset mid-DETECT behaves like power-on.

Decomposition:
- Package repairclk_pkg holds:
  - the FSM state encoding (IDLE, DETECT, DONE, HOLD);
  - the lane state encoding (HUNT, CHECK);
  - the lane-bit index constants RCKP=0, RCKN=1, RTRK=2;
  - a function computing W from the parameters.
- Sub-module repairclk_lane_detector: per-lane HUNT/CHECK logic, position counter, consec counter, pass flag. Instantiated three times.
- The top level holds the FSM, the window counter and the result register.

Test Plan:
- Ideal pattern on all three lanes for 128 iterations, i_detect_en held → o_clk_track_done pulses at cycle 3088 after DETECT entry; result 3'b111; o_busy high for 3088 cycles.
- RCKN stuck at 0, other lanes ideal → result 3'b101. Repeat with RCKP stuck at 1 → 3'b110.
- RTRK: flip one UI in every 10th iteration (at most 9 consecutive clean iterations) → bit2=0. Flip a single UI only in iteration 50 → bit2=1.
- i_detect_en dropped after 15 clean iterations → early DONE; result 3'b000. Repeat after 16 clean iterations → 3'b111.
- i_clear_clk_detection pulsed mid-DETECT and again in HOLD after a 3'b111 result → no done strobe; result 0; FSM returns to IDLE then re-enters DETECT while i_detect_en is high.
- rst asserted mid-DETECT → next cycle: all outputs 0, state IDLE; a clean rerun gives 3'b111.
